panel_event_ctrl: RTL
=====================

PANEL_EVENT_CTRL -- requirements
Module: panel_event_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 1000: PLD_MCLK cycles per debounce sample tick, legal range 16..65535.
REQ-002 Parameter DEB_SAMPLES, default 4: consecutive equal samples needed to accept a key level change, legal range 2..15.
REQ-003 Parameter FIFO_DEPTH, default 8: key-event queue depth, power of two, legal range 2..16.
REQ-004 PLD_MCLK  in  1  sole clock, all logic rising-edge.
REQ-005 EPL_RESETN  in  1  asynchronous, active-low reset.
REQ-006 key_i  in  12  raw buttons, active-low (0 = pressed); bit order UP,DN,LFT,RHT,ENT,ESC,ST[0..5] = idx 0..11.
REQ-007 enc_a_i, enc_b_i  in  2 each  raw quadrature inputs; encoder 0 = RIN1/RIN2, encoder 1 = REX1/REX2.
REQ-008 evt_rd_i  in  1  pop strobe from the EPL register side, one pop per high cycle.
REQ-009 clr_err_i  in  1  clears the sticky ovf/enc-error flags.
REQ-010 key_state_o  out  12  debounced levels, 1 = pressed.
REQ-011 enc_pos0_o, enc_pos1_o  out  8 each  two's-complement position counters.
REQ-012 evt_valid_o  out  1  queue non-empty; evt_data_o  out  8  head event {press, 3'b000, idx[3:0]}.
REQ-013 evt_ovf_o  out  1  sticky queue overflow; enc_err_o  out  2  sticky illegal-transition flag per encoder.

Function
REQ-014 All raw inputs SHALL pass through a 2-flop synchronizer before any use.
REQ-015 A free-running prescaler SHALL assert a one-cycle tick every TICK_DIV cycles, first tick TICK_DIV cycles after reset release.
REQ-016 Per key, on each tick: sample equal to current debounced level -> counter cleared; differing -> counter +1; key_state_o toggles on the cycle after the tick where counter reaches DEB_SAMPLES, counter then clears.
REQ-017 A glitch shorter than DEB_SAMPLES ticks SHALL produce no state change and no event.
REQ-018 Each key_state_o change SHALL set that key's pending bit; each cycle the lowest-index pending bit is cleared and its event (press = new level) pushed.
REQ-019 Several keys changing on the same tick SHALL be queued in ascending index order, one per cycle.
REQ-020 Queue is first-word-fall-through: evt_valid_o and evt_data_o valid the cycle after a push into an empty queue.
REQ-021 evt_rd_i with queue empty SHALL be ignored; no underflow, pointers unchanged.
REQ-022 Push while full and no pop: event dropped, evt_ovf_o set; push and pop in the same cycle while full: both take effect, no overflow.
REQ-023 Encoders decoded x4 every clock from synchronized A/B: Gray step A-leads-B -> +1, B-leads-A -> -1, no change -> hold.
REQ-024 Both A and B changing in one cycle SHALL leave the position unchanged and set the encoder's enc_err_o bit.
REQ-025 Position counters SHALL wrap modulo 256 (127+1 = -128, -128-1 = 127).
REQ-026 clr_err_i clears evt_ovf_o and enc_err_o; a new error event in the same cycle wins (flag stays 1).

Reset
REQ-027 EPL_RESETN low SHALL immediately clear: synchronizers to released/idle (key 1, A/B 0), key_state_o 0, counters, prescaler, pending bits, queue empty (evt_valid_o 0, evt_data_o 0), enc_pos 0, all sticky flags 0.
REQ-028 Reset asserted mid-debounce or with a non-empty queue SHALL discard all in-flight state; no event is emitted for it after release.
REQ-029 After release, the first synchronized encoder sample SHALL be taken as reference without counting or flagging.

Structure
REQ-030 Shared package panel_pkg SHALL hold NUM_KEYS = 12, key index constants KEY_UP..KEY_ST5, event field positions (EVT_PRESS_BIT = 7, EVT_IDX_LSB = 0, EVT_IDX_W = 4).
REQ-031 The event queue SHALL be a separate sub-module panel_evt_fifo (width 8, depth FIFO_DEPTH); debounce and quadrature logic stay inline.

Verification (TICK_DIV = 16, DEB_SAMPLES = 3 unless stated)
REQ-032 Hold key_i[4] low 100 cycles -> key_state_o[4] = 1, evt_data_o = 8'h84, evt_valid_o = 1; release -> 8'h04 queued.
REQ-033 Pulse key_i[0] low for 2 ticks -> key_state_o and queue unchanged.
REQ-034 Press keys 7 and 2 simultaneously -> queue order 8'h82 then 8'h87; nine single presses with FIFO_DEPTH = 8, no pops -> 8 events kept, evt_ovf_o = 1; clr_err_i -> 0.
REQ-035 Encoder 0: 130 forward Gray steps from 0 -> enc_pos0_o = 8'h82 (-126); swap A/B in one cycle -> no count, enc_err_o[0] = 1.
REQ-036 Assert EPL_RESETN low with 3 queued events and a key mid-debounce -> all outputs 0 within the same cycle; after release no event appears until a fresh debounced change.

Source files
------------

// File: rtl/panel_pkg.sv
// Shared definitions for the front-panel key/encoder event controller.
package panel_pkg;

  localparam int NUM_KEYS = 12;
  localparam int NUM_ENC  = 2;

  // Key indices: navigation keys first, then the six soft keys ST0..ST5.
  localparam int KEY_UP  = 0;
  localparam int KEY_DN  = 1;
  localparam int KEY_LFT = 2;
  localparam int KEY_RHT = 3;
  localparam int KEY_ENT = 4;
  localparam int KEY_ESC = 5;
  localparam int KEY_ST0 = 6;
  localparam int KEY_ST1 = 7;
  localparam int KEY_ST2 = 8;
  localparam int KEY_ST3 = 9;
  localparam int KEY_ST4 = 10;
  localparam int KEY_ST5 = 11;

  // Event word layout: {press, 3'b000, idx[3:0]}.
  localparam int EVT_W         = 8;
  localparam int EVT_PRESS_BIT = 7;
  localparam int EVT_IDX_LSB   = 0;
  localparam int EVT_IDX_W     = 4;

  // Builds one queue entry from the new key level and the key index.
  function automatic logic [EVT_W-1:0] mk_evt(input logic press,
                                              input logic [EVT_IDX_W-1:0] idx);
    logic [EVT_W-1:0] e;
    e = '0;
    e[EVT_PRESS_BIT] = press;
    e[EVT_IDX_LSB +: EVT_IDX_W] = idx;
    return e;
  endfunction

endpackage

// File: rtl/panel_evt_fifo.sv
// First-word-fall-through event queue; flags a push that had to be dropped.
module panel_evt_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              ovf_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW:0]       cnt_q;
  logic              empty;
  logic              full;
  logic              do_pop;
  logic              do_push;

  // A pop frees a slot in the same cycle, so a full queue may still accept a push.
  always_comb begin
    empty   = (cnt_q == '0);
    full    = (cnt_q == (AW+1)'(DEPTH));
    do_pop  = pop_i && !empty;
    do_push = push_i && (!full || do_pop);
    ovf_o   = push_i && full && !do_pop;
    valid_o = !empty;
    data_o  = empty ? '0 : mem_q[rd_ptr_q];
  end

  // Storage and pointers; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/panel_event_ctrl.sv
// Front-panel controller: key debounce with event queue, two x4 quadrature encoders.
module panel_event_ctrl
  import panel_pkg::*;
#(
  parameter int TICK_DIV    = 1000,
  parameter int DEB_SAMPLES = 4,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                PLD_MCLK,
  input  logic                EPL_RESETN,
  input  logic [NUM_KEYS-1:0] key_i,
  input  logic [1:0]          enc_a_i,
  input  logic [1:0]          enc_b_i,
  input  logic                evt_rd_i,
  input  logic                clr_err_i,
  output logic [NUM_KEYS-1:0] key_state_o,
  output logic [7:0]          enc_pos0_o,
  output logic [7:0]          enc_pos1_o,
  output logic                evt_valid_o,
  output logic [EVT_W-1:0]    evt_data_o,
  output logic                evt_ovf_o,
  output logic [1:0]          enc_err_o
);

  // Gray phase index along the A-leads-B sequence 00 -> 10 -> 11 -> 01.
  function automatic logic [1:0] quad_idx(input logic a, input logic b);
    return {b, a ^ b};
  endfunction

  logic [NUM_KEYS-1:0]  key_sync_p0, key_sync_p1;
  logic [NUM_ENC-1:0]   enc_a_p0, enc_a_p1, enc_b_p0, enc_b_p1;
  logic [15:0]          div_cnt_q;
  logic                 tick_q;
  logic [3:0]           deb_cnt_q [NUM_KEYS];
  logic [3:0]           deb_cnt_d [NUM_KEYS];
  logic [NUM_KEYS-1:0]  key_state_q, key_state_d, key_chg;
  logic [NUM_KEYS-1:0]  pend_q, pend_d, pend_clr;
  logic [EVT_IDX_W-1:0] evt_idx;
  logic                 evt_push;
  logic [EVT_W-1:0]     evt_push_data;
  logic                 fifo_ovf;
  logic                 ovf_q;
  logic [1:0]           enc_prev_q [NUM_ENC];
  logic [1:0]           enc_warm_q;
  logic signed [7:0]    enc_pos_q [NUM_ENC];
  logic signed [7:0]    enc_pos_d [NUM_ENC];
  logic [NUM_ENC-1:0]   enc_err_q, enc_err_set;
  logic [1:0]           enc_diff;

  // Two-flop synchronizers; idle levels are key released, encoder lines low.
  always_ff @(posedge PLD_MCLK or negedge EPL_RESETN) begin
    if (!EPL_RESETN) begin
      key_sync_p0 <= '1;
      key_sync_p1 <= '1;
      enc_a_p0    <= '0;
      enc_a_p1    <= '0;
      enc_b_p0    <= '0;
      enc_b_p1    <= '0;
    end else begin
      key_sync_p0 <= key_i;
      key_sync_p1 <= key_sync_p0;
      enc_a_p0    <= enc_a_i;
      enc_a_p1    <= enc_a_p0;
      enc_b_p0    <= enc_b_i;
      enc_b_p1    <= enc_b_p0;
    end
  end

  // Debounce: a key level flips after DEB_SAMPLES consecutive differing tick samples.
  always_comb begin
    key_state_d = key_state_q;
    key_chg     = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      deb_cnt_d[k] = deb_cnt_q[k];
      if (tick_q) begin
        if (!key_sync_p1[k] == key_state_q[k]) begin
          deb_cnt_d[k] = '0;
        end else if (deb_cnt_q[k] == 4'(DEB_SAMPLES - 1)) begin
          deb_cnt_d[k]   = '0;
          key_state_d[k] = ~key_state_q[k];
          key_chg[k]     = 1'b1;
        end else begin
          deb_cnt_d[k] = deb_cnt_q[k] + 4'd1;
        end
      end
    end
  end

  // Serialize pending changes into the queue, lowest key index first.
  always_comb begin
    evt_push = |pend_q;
    evt_idx  = '0;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (pend_q[k]) evt_idx = EVT_IDX_W'(k);
    end
    pend_clr      = pend_q & (~pend_q + 1'b1);
    pend_d        = (pend_q & ~pend_clr) | key_chg;
    evt_push_data = mk_evt(key_state_q[evt_idx], evt_idx);
  end

  // x4 decode; a double-line change is illegal and leaves the count alone.
  always_comb begin
    enc_diff = '0;
    for (int e = 0; e < NUM_ENC; e++) begin
      enc_pos_d[e]   = enc_pos_q[e];
      enc_err_set[e] = 1'b0;
      enc_diff = quad_idx(enc_a_p1[e], enc_b_p1[e]) -
                 quad_idx(enc_prev_q[e][1], enc_prev_q[e][0]);
      if (enc_warm_q == 2'd3) begin
        case (enc_diff)
          2'd1:    enc_pos_d[e]   = enc_pos_q[e] + 8'sd1;
          2'd3:    enc_pos_d[e]   = enc_pos_q[e] - 8'sd1;
          2'd2:    enc_err_set[e] = 1'b1;
          default: enc_pos_d[e]   = enc_pos_q[e];
        endcase
      end
    end
  end

  // Prescaler, debounce, pending, encoder state and sticky error flags.
  always_ff @(posedge PLD_MCLK or negedge EPL_RESETN) begin
    if (!EPL_RESETN) begin
      div_cnt_q   <= '0;
      tick_q      <= 1'b0;
      for (int k = 0; k < NUM_KEYS; k++) deb_cnt_q[k] <= '0;
      key_state_q <= '0;
      pend_q      <= '0;
      ovf_q       <= 1'b0;
      enc_warm_q  <= '0;
      for (int e = 0; e < NUM_ENC; e++) begin
        enc_prev_q[e] <= '0;
        enc_pos_q[e]  <= '0;
      end
      enc_err_q   <= '0;
    end else begin
      if (div_cnt_q == 16'(TICK_DIV - 1)) begin
        div_cnt_q <= '0;
        tick_q    <= 1'b1;
      end else begin
        div_cnt_q <= div_cnt_q + 16'd1;
        tick_q    <= 1'b0;
      end
      for (int k = 0; k < NUM_KEYS; k++) deb_cnt_q[k] <= deb_cnt_d[k];
      key_state_q <= key_state_d;
      pend_q      <= pend_d;
      ovf_q       <= (clr_err_i ? 1'b0 : ovf_q) | fifo_ovf;
      // Reference is latched once the synchronizers hold real input samples.
      if (enc_warm_q != 2'd3) enc_warm_q <= enc_warm_q + 2'd1;
      for (int e = 0; e < NUM_ENC; e++) begin
        enc_prev_q[e] <= {enc_a_p1[e], enc_b_p1[e]};
        enc_pos_q[e]  <= enc_pos_d[e];
      end
      enc_err_q   <= (clr_err_i ? '0 : enc_err_q) | enc_err_set;
    end
  end

  panel_evt_fifo #(
    .DATA_W (EVT_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_evt_fifo (
    .clk_i   (PLD_MCLK),
    .rst_ni  (EPL_RESETN),
    .push_i  (evt_push),
    .data_i  (evt_push_data),
    .pop_i   (evt_rd_i),
    .valid_o (evt_valid_o),
    .data_o  (evt_data_o),
    .ovf_o   (fifo_ovf)
  );

  assign key_state_o = key_state_q;
  assign enc_pos0_o  = enc_pos_q[0];
  assign enc_pos1_o  = enc_pos_q[1];
  assign evt_ovf_o   = ovf_q;
  assign enc_err_o   = enc_err_q;

endmodule
